// File: rtl/uart_tx_fifo_if.sv
// Client-side bundle for the FIFO-fed UART transmitter: oversampling tick,
// push port, per-frame configuration, serial line and status flags.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_tick;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic [1:0]            parity_mode;
    logic                  stop2;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  full;
    logic                  empty;
    logic                  overflow;

    modport master (
        output s_tick, wr_en, din, parity_mode, stop2,
        input  tx, tx_busy, tx_done, full, empty, overflow
    );

    modport slave (
        input  s_tick, wr_en, din, parity_mode, stop2,
        output tx, tx_busy, tx_done, full, empty, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO. Frame format (parity,
// one or two stop bits) is latched when a word is popped, so config changes
// only affect the next frame. Queued words go out as back-to-back frames.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_ADDR  = 4
) (
    input logic           clk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_ADDR;
    localparam int unsigned SW    = $clog2(OVERSAMPLE);
    localparam int unsigned NW    = $clog2(DATA_WIDTH);

    localparam logic [SW-1:0]      S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0]      S_ONE    = SW'(1);
    localparam logic [NW-1:0]      N_LAST   = NW'(DATA_WIDTH - 1);
    localparam logic [NW-1:0]      N_ONE    = NW'(1);
    localparam logic [FIFO_ADDR-1:0] PTR_ONE = FIFO_ADDR'(1);
    localparam logic [FIFO_ADDR:0] CNT_ONE  = (FIFO_ADDR + 1)'(1);
    localparam logic [FIFO_ADDR:0] CNT_FULL = (FIFO_ADDR + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_ADDR-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR:0]    count_q, count_d;
    logic                  full_q, empty_q, overflow_q;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head;

    // Serialiser state
    state_e                state_q, state_d;
    logic [SW-1:0]         s_q, s_d;
    logic [NW-1:0]         n_q, n_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            pmode_q, pmode_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  bit_end, load, par_en, par_bit;

    // A full FIFO refuses writes even when a pop lands in the same cycle.
    assign push    = bus.wr_en && !full_q;
    assign head    = mem_q[rd_ptr_q];
    assign par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign par_bit = (^data_q) ^ (pmode_q == 2'b10);

    // Occupancy update from simultaneous push/pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage array: no reset, contents are invalidated via the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    // FIFO pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= bus.wr_en && full_q;
        end
    end

    // Frame FSM next-state, tick/bit counters and line level.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        pmode_d = pmode_q;
        stop2_d = stop2_q;
        pop     = 1'b0;
        load    = 1'b0;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        bit_end = bus.s_tick && (s_q == S_LAST);
        if (bus.s_tick && !bit_end) begin
            s_d = s_q + S_ONE;
        end
        unique case (state_q)
            StIdle: begin
                s_d  = '0;
                load = !empty_q;
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    s_d     = '0;
                    n_d     = '0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_d = shreg_q[0];
                if (bit_end) begin
                    s_d     = '0;
                    shreg_d = shreg_q >> 1;
                    if (n_q == N_LAST) begin
                        n_d     = '0;
                        state_d = par_en ? StParity : StStop;
                    end else begin
                        n_d = n_q + N_ONE;
                    end
                end
            end
            StParity: begin
                tx_d = par_bit;
                if (bit_end) begin
                    s_d     = '0;
                    n_d     = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                // n counts the first stop bit of a two-stop-bit frame
                if (bit_end) begin
                    s_d = '0;
                    if (stop2_q && (n_q == '0)) begin
                        n_d = N_ONE;
                    end else begin
                        n_d    = '0;
                        done_d = 1'b1;
                        if (!empty_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            pop     = 1'b1;
            shreg_d = head;
            data_d  = head;
            pmode_d = bus.parity_mode;
            stop2_d = bus.stop2;
            s_d     = '0;
            n_d     = '0;
            state_d = StStart;
        end
    end

    // Serialiser registers; tx lags the state by one registered stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            pmode_q <= '0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            pmode_q <= pmode_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_busy  = (state_q != StIdle);
    assign bus.tx_done  = done_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of queued words, frames
// captured cell by cell from the tx line and compared against the expected
// bit sequence.
module tb_uart_tx_fifo;
    localparam int unsigned OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] pm;
        logic       st2;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    sb_t  sb[$];

    uart_tx_fifo_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_fifo #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(OS),
        .FIFO_ADDR (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected frame: start, data LSB first, optional parity, stop bit(s).
    function automatic void frame_bits(input sb_t e, output logic [11:0] v, output int n);
        v = '0;
        n = 0;
        v[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            v[n] = e.data[i];
            n++;
        end
        if (e.pm == 2'b01 || e.pm == 2'b10) begin
            v[n] = (^e.data) ^ (e.pm == 2'b10);
            n++;
        end
        v[n] = 1'b1;
        n++;
        if (e.st2) begin
            v[n] = 1'b1;
            n++;
        end
    endfunction

    // Push one word for one cycle and record it as expected output.
    task automatic send(input logic [7:0] d);
        sb_t e;
        bus.wr_en = 1'b1;
        bus.din   = d;
        e.data = d;
        e.pm   = bus.parity_mode;
        e.st2  = bus.stop2;
        sb.push_back(e);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Wait for a start bit, then sample tx every cycle of nbits cells.
    task automatic capture_frame(input int nbits, output bit timeout, output int gap,
                                 output logic [11:0] bits, output bit steady,
                                 output int done_cnt, output bit done_last,
                                 output int busy_low, output bit busy_last);
        timeout = 1'b0; gap = 0; bits = '0; steady = 1'b1;
        done_cnt = 0; done_last = 1'b0; busy_low = 0; busy_last = 1'b0;
        while (bus.tx !== 1'b0 && gap < 3000) begin
            @(negedge clk);
            gap++;
        end
        if (bus.tx !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        for (int c = 0; c < nbits; c++) begin
            for (int k = 0; k < int'(OS); k++) begin
                if (k == 0) bits[c] = bus.tx;
                else if (bus.tx !== bits[c]) steady = 1'b0;
                if (bus.tx_done === 1'b1) begin
                    done_cnt++;
                    if (c == nbits - 1 && k == int'(OS) - 1) done_last = 1'b1;
                end
                if (c == nbits - 1 && k == int'(OS) - 1) busy_last = bus.tx_busy;
                else if (bus.tx_busy !== 1'b1) busy_low++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b0;
        send(8'h55);
        send(8'hC3);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        total++; if (bus.tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    endtask

    task automatic test_basic_frame();
        bit to, st, dl, bl;
        int gap, dc, blow;
        logic [11:0] bits;
        logic [9:0] want;
        want = {1'b1, 8'hA5, 1'b0};
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b0;
        send(8'hA5);
        total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL basic_empty_drop: got %b want 0", bus.empty); end
        void'(sb.pop_front());
        capture_frame(10, to, gap, bits, st, dc, dl, blow, bl);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", to); end
        total++; if (gap !== 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", gap); end
        total++; if (bits[9:0] !== want) begin bad++; $display("FAIL basic_bits: got %b want %b", bits[9:0], want); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL basic_bit_len: got %b want 1", st); end
        total++; if (dc !== 1 || dl !== 1'b1) begin bad++; $display("FAIL basic_done: got cnt=%0d last=%b want 1/1", dc, dl); end
        total++; if (blow !== 0) begin bad++; $display("FAIL basic_busy: got low=%0d want 0", blow); end
        @(negedge clk);
        total++; if (bus.tx_busy !== 1'b0 || bus.tx !== 1'b1) begin
            bad++; $display("FAIL basic_idle_after: got busy=%b tx=%b want 0/1", bus.tx_busy, bus.tx);
        end
    endtask

    task automatic test_parity();
        bit to, st, dl, bl;
        int gap, dc, blow, n;
        logic [11:0] bits, v;
        sb_t e;
        for (int m = 0; m < 2; m++) begin
            bus.parity_mode = (m == 0) ? 2'b01 : 2'b10;
            bus.stop2 = 1'b0;
            send(8'h07);
            e = sb.pop_front();
            frame_bits(e, v, n);
            capture_frame(n, to, gap, bits, st, dc, dl, blow, bl);
            total++; if (n !== 11) begin bad++; $display("FAIL parity_len: got %0d want 11", n); end
            total++; if (to !== 1'b0 || bits !== v || st !== 1'b1) begin
                bad++; $display("FAIL parity_frame%0d: got %b want %b", m, bits, v);
            end
            total++; if (bits[9] !== ((m == 0) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL parity_bit%0d: got %b want %b", m, bits[9], (m == 0));
            end
            total++; if (dc !== 1 || dl !== 1'b1) begin bad++; $display("FAIL parity_done%0d: got %0d", m, dc); end
        end
    endtask

    task automatic test_back_to_back();
        bit to, st, dl, bl;
        int gap, dc, blow, n;
        logic [11:0] bits, v;
        sb_t e;
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b1;
        send(8'h00);
        send(8'hFF);
        for (int f = 0; f < 2; f++) begin
            e = sb.pop_front();
            frame_bits(e, v, n);
            capture_frame(n, to, gap, bits, st, dc, dl, blow, bl);
            total++; if (to !== 1'b0 || bits !== v || st !== 1'b1) begin
                bad++; $display("FAIL b2b_frame%0d: got %b want %b", f, bits, v);
            end
            total++; if (dc !== 1 || dl !== 1'b1) begin
                bad++; $display("FAIL b2b_done%0d: got cnt=%0d last=%b want 1/1", f, dc, dl);
            end
            total++; if (blow !== 0) begin bad++; $display("FAIL b2b_busy%0d: got low=%0d want 0", f, blow); end
            if (f == 0) begin
                total++; if (bl !== 1'b1) begin bad++; $display("FAIL b2b_busy_gap: got %b want 1", bl); end
            end else begin
                total++; if (gap !== 0) begin bad++; $display("FAIL b2b_start_gap: got %0d want 0", gap); end
            end
        end
        bus.stop2 = 1'b0;
    endtask

    task automatic test_overflow();
        bit to, st, dl, bl;
        int gap, dc, blow, n, errs;
        logic [11:0] bits, v;
        sb_t e;
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b0;
        bus.s_tick = 1'b0;
        // A first word parks in the shift register so the FIFO itself fills.
        send(8'hEE);
        repeat (3) @(negedge clk);
        for (int i = 0; i <= 16; i++) begin
            total++; if (bus.full !== (i == 16)) begin bad++; $display("FAIL ovf_full%0d: got %b want %b", i, bus.full, (i == 16)); end
            total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early%0d: got %b want 0", i, bus.overflow); end
            bus.wr_en = 1'b1;
            bus.din = 8'(i);
            if (i < 16) begin
                e.data = 8'(i); e.pm = 2'b00; e.st2 = 1'b0;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
        @(negedge clk);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_width: got %b want 0", bus.overflow); end
        bus.s_tick = 1'b1;
        @(negedge clk);
        errs = 0;
        for (int f = 0; f < 17; f++) begin
            e = sb.pop_front();
            frame_bits(e, v, n);
            capture_frame(n, to, gap, bits, st, dc, dl, blow, bl);
            if (to || bits !== v || st !== 1'b1) begin
                errs++;
                $display("FAIL ovf_order%0d: got %b want %b", f, bits, v);
            end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL ovf_frames: got %0d bad frames want 0", errs); end
        repeat (40) @(negedge clk);
        total++; if (bus.empty !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx !== 1'b1) begin
            bad++; $display("FAIL ovf_drained: got empty=%b busy=%b tx=%b want 1/0/1", bus.empty, bus.tx_busy, bus.tx);
        end
    endtask

    task automatic test_reset_mid_data();
        int w, lows, dones;
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b0;
        send(8'h3C);
        send(8'h5A);
        w = 0;
        while (bus.tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        total++; if (bus.tx !== 1'b0) begin bad++; $display("FAIL rmd_start: got %b want 0", bus.tx); end
        repeat (int'(OS) * 4 + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL rmd_tx: got %b want 1", bus.tx); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rmd_empty: got %b want 1", bus.empty); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL rmd_busy: got %b want 0", bus.tx_busy); end
        reset = 1'b0;
        sb.delete();
        lows = 0;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
            if (bus.tx_done !== 1'b0) dones++;
        end
        total++; if (lows !== 0 || dones !== 0) begin
            bad++; $display("FAIL rmd_no_frames: got low=%0d done=%0d want 0/0", lows, dones);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.s_tick = 1'b1;
        bus.wr_en = 1'b0;
        bus.din = '0;
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, runtime-selectable parity and one or two stop bits. It sits between a byte-producing client (CPU bus bridge, packetiser) and the TX pin. It shares the external oversampling tick generator (`s_tick`) with the UART receiver. Clients push words without waiting on the serialiser, and queued words go out as back-to-back frames.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; legal range 2..256.
- `FIFO_ADDR`, 4: FIFO depth is 2^FIFO_ADDR words.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_tick`  in  1  oversampling enable, one `clk` cycle wide.
- `wr_en`  in  1  push `din` into the FIFO.
- `din`  in  DATA_WIDTH  word to transmit, sent LSB first.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop2`  in  1  1 = two stop bits, 0 = one stop bit.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's stop period.
- `full`  out  1  FIFO holds 2^FIFO_ADDR words.
- `empty`  out  1  FIFO holds zero words.
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- FIFO
  - A write occurs when `wr_en` is high and `full` is low.
  - When `wr_en` is high and `full` is high, the word is dropped and `overflow` pulses on the next cycle.
  - A write is blocked while `full` is high, even if a pop happens in the same cycle.
  - Pointers are FIFO_ADDR bits wide and wrap modulo depth. An extra occupancy bit or counter separates full from empty.
  - `full` and `empty` are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `tx` = 1.
  - If `empty` is low: pop the head word into a shift register and latch `parity_mode` and `stop2` for the whole frame. Then go to START.
  - Config changes mid-frame take effect on the next frame only.
- Tick counter `s`, width ceil(log2(OVERSAMPLE)):
  - Cleared on entry to each state.
  - On `s_tick`: if `s` == OVERSAMPLE-1, the bit ends; otherwise `s` increments.
  - A bit lasts exactly OVERSAMPLE ticks.
- START
  - `tx` = 0 for one bit, then go to DATA with bit counter `n` = 0.
- DATA
  - `tx` = shift register bit 0.
  - At each bit end, shift right and increment `n`.
  - After bit DATA_WIDTH-1, go to PARITY if parity is enabled, else go to STOP.
- PARITY
  - `tx` = XOR of all data bits for even parity, or its inverse for odd parity.
  - Parity is computed from the word latched at pop, not from the shifted register.
  - Lasts one bit, then go to STOP.
- STOP
  - `tx` = 1 for OVERSAMPLE ticks, or 2*OVERSAMPLE ticks when `stop2` is set.
  - At the end: pulse `tx_done`.
  - If `empty` is low, pop the next word in the same cycle and go directly to START. There is no idle gap and `tx_busy` stays high.
  - Otherwise go to IDLE.
- Reset
  - Values after reset: `tx`=1, `tx_busy`=0, `tx_done`=0, `full`=0, `empty`=1, `overflow`=0. Pointers, counters, shift register and state are cleared.
  - Reset during any state aborts the frame. `tx` is high on the cycle after reset and the FIFO contents are discarded.

## Timing
- `tx`, `tx_done`, `overflow`, `full` and `empty` are registered outputs. `tx_busy` is decoded from the state register.
- Write to an empty FIFO at cycle N: `empty` drops at N+1, the FSM pops at N+1, the state is START at N+2, and `tx` falls at N+3 (one registered stage).
- Frame length in ticks: OVERSAMPLE × (1 + DATA_WIDTH + P + S), where P is 0 or 1 and S is 1 or 2.
- `tx_done` is high in the cycle after the final stop tick. A new frame's `tx`=0 follows in the next cycle.
- A write and a pop in the same cycle, with the FIFO neither full nor empty, leave occupancy unchanged.
- `s_tick` held low stalls the frame indefinitely with `tx` stable.

## Test plan
- Reset sequence: assert `reset` for 3 cycles mid-stream. Required on the next cycle: `tx`=1, `tx_busy`=0, `empty`=1, `full`=0, `tx_done`=0.
- Basic frame: DATA_WIDTH=8, OVERSAMPLE=16, `s_tick` every cycle, write 0xA5, no parity, one stop bit.
  - `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each held 16 cycles (160 total).
  - Exactly one `tx_done` pulse; `tx_busy` low afterwards.
- Parity: send 0x07 with even parity; parity bit must be 1. Send it again with odd parity; parity bit must be 0. Frame is 11 bits.
- Back-to-back with two stop bits: write 0x00 and 0xFF in consecutive cycles with `stop2`=1.
  - Stop period is 32 ticks.
  - The second start bit immediately follows the first frame's stop.
  - `tx_busy` never drops between frames; two `tx_done` pulses.
- Overflow and ordering: FIFO_ADDR=4, `s_tick`=0, write 0x00..0x10 (17 words).
  - `full`=1 after the 16th write.
  - The 17th write produces an `overflow` pulse.
  - With `s_tick` then enabled, exactly 0x00..0x0F are transmitted in order.
- Reset mid-DATA: assert `reset` during bit 3 of a frame. Required: `tx`=1 next cycle, `empty`=1, and no further frames are transmitted.
